// File: rtl/spatz_cache_arb_pkg.sv
// Shared types and helpers for the Spatz cache-side bank-aware arbiter.
// Provides width helpers, a reference round-robin search and the default payload type.
package spatz_cache_arb_pkg;

   localparam int unsigned MaxInp = 32;

   // Default payload; any DATA_T override must also carry an `addr` field.
   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } req_t;

   // Source of the candidate mask fed to the round-robin picker.
   typedef enum logic [1:0] {
      SRC_LOCK,
      SRC_STARVED,
      SRC_BANK,
      SRC_RR
   } cand_src_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned wait_width(input int unsigned max_wait);
      return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
   endfunction

   // First set bit of mask[n-1:0] found from `start` upward with wrap-around; 0 if none.
   function automatic int unsigned rr_first(input logic [MaxInp-1:0] mask,
                                            input int unsigned       start,
                                            input int unsigned       n);
      int unsigned j;
      rr_first = 0;
      for (int unsigned k = 0; k < n; k++) begin
         j = start + (n - 1 - k);
         if (j >= n) j = j - n;
         if (mask[j]) rr_first = j;
      end
   endfunction

endpackage

// File: rtl/spatz_cache_rr_pick.sv
// Combinational round-robin picker: rotate the mask to start, count trailing zeros,
// then rotate the resulting offset back into a port index.
module spatz_cache_rr_pick
   import spatz_cache_arb_pkg::*;
#(
   parameter int unsigned NumInp = 4,
   localparam int unsigned IdxW  = idx_width(NumInp)
) (
   input  logic [NumInp-1:0] mask,
   input  logic [IdxW-1:0]   start,
   output logic [IdxW-1:0]   idx,
   output logic              empty
);

   logic [NumInp-1:0] rot;
   logic [IdxW-1:0]   cnt;

   always_comb begin
      rot = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         int unsigned j;
         j = i + int'(start);
         if (j >= NumInp) j = j - NumInp;
         rot[i] = mask[j];
      end
   end

   // Descending scan so the lowest set offset is the one that sticks.
   always_comb begin
      cnt = '0;
      for (int unsigned i = NumInp; i > 0; i--) begin
         if (rot[i-1]) cnt = IdxW'(i - 1);
      end
   end

   always_comb begin
      int unsigned s;
      s = int'(start) + int'(cnt);
      if (s >= NumInp) s = s - NumInp;
      idx = IdxW'(s);
   end

   assign empty = ~|mask;

endmodule

// File: rtl/spatz_cache_bank_arb.sv
// N-to-1 bank-aware arbiter: prefers a bank different from the last accept, bounds
// starvation with per-port wait counters and holds the grant while downstream stalls.
module spatz_cache_bank_arb
   import spatz_cache_arb_pkg::*;
#(
   parameter type          DATA_T   = req_t,
   parameter int unsigned  NumInp   = 4,
   parameter int unsigned  Offset   = 0,
   parameter int unsigned  BankBits = 1,
   parameter int unsigned  MaxWait  = 7,
   localparam int unsigned IdxW     = idx_width(NumInp),
   localparam int unsigned WaitW    = wait_width(MaxWait)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  DATA_T             inp_data_i [NumInp],
   input  logic [NumInp-1:0] inp_valid_i,
   output logic [NumInp-1:0] inp_ready_o,
   output DATA_T             oup_data_o,
   output logic              oup_valid_o,
   input  logic              oup_ready_i,
   output logic [IdxW-1:0]   oup_idx_o
);

   logic [IdxW-1:0]     rr_q;
   logic [BankBits-1:0] bank_q;
   logic                bank_vld_q;
   logic                lock_q;
   logic [IdxW-1:0]     lock_idx_q;
   logic [WaitW-1:0]    wait_q [NumInp];

   logic [BankBits-1:0] bank [NumInp];
   logic [NumInp-1:0]   starved;
   logic [NumInp-1:0]   preferred;
   logic [NumInp-1:0]   cand;
   cand_src_e           src;
   logic [IdxW-1:0]     start;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_empty;
   logic [IdxW-1:0]     sel;
   logic                hs;
   logic                stall;

   always_comb begin
      for (int unsigned i = 0; i < NumInp; i++) begin
         bank[i]      = inp_data_i[i].addr[Offset +: BankBits];
         starved[i]   = (MaxWait > 0) && inp_valid_i[i] && (wait_q[i] == WaitW'(MaxWait));
         preferred[i] = bank_vld_q && inp_valid_i[i] && (bank[i] != bank_q);
      end
   end

   always_comb begin
      src  = SRC_RR;
      cand = inp_valid_i;
      if (lock_q) begin
         src = SRC_LOCK;
      end else if (|starved) begin
         src  = SRC_STARVED;
         cand = starved;
      end else if (|preferred) begin
         src  = SRC_BANK;
         cand = preferred;
      end
   end

   assign start = (rr_q == IdxW'(NumInp - 1)) ? '0 : rr_q + 1'b1;

   spatz_cache_rr_pick #(
      .NumInp (NumInp)
   ) i_rr_pick (
      .mask  (cand),
      .start (start),
      .idx   (pick_idx),
      .empty (pick_empty)
   );

   always_comb begin
      case (src)
         SRC_LOCK: sel = lock_idx_q;
         default:  sel = pick_empty ? '0 : pick_idx;
      endcase
   end

   always_comb begin
      inp_ready_o      = '0;
      inp_ready_o[sel] = oup_ready_i & inp_valid_i[sel];
   end

   assign oup_valid_o = inp_valid_i[sel];
   assign oup_data_o  = inp_data_i[sel];
   assign oup_idx_o   = sel;
   assign hs          = oup_valid_o & oup_ready_i;

   // An already-locked grant stays locked if its valid drops while stalled,
   // so an upstream protocol violation never migrates the grant to another port.
   assign stall = (oup_valid_o | lock_q) & ~oup_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= IdxW'(NumInp - 1);
         bank_q     <= '0;
         bank_vld_q <= 1'b0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         for (int unsigned i = 0; i < NumInp; i++) wait_q[i] <= '0;
      end else begin
         bank_vld_q <= hs;
         lock_q     <= stall;
         if (stall) lock_idx_q <= sel;
         if (hs) begin
            rr_q   <= sel;
            bank_q <= bank[sel];
            for (int unsigned i = 0; i < NumInp; i++) begin
               if (IdxW'(i) == sel) begin
                  wait_q[i] <= '0;
               end else if (inp_valid_i[i] && (wait_q[i] != WaitW'(MaxWait))) begin
                  wait_q[i] <= wait_q[i] + 1'b1;
               end
            end
         end
      end
   end

endmodule
